trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 173 +++++++++++++++++
 tb/tb_trap_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module   : trap_ctrl
// Brief    : Machine-mode trap entry / MRET sequencer (IDLE-SAVE|RESTORE-REDIRECT)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_in,
   input  logic        instr_valid_in,
   input  logic [63:0] pc_in,
   input  logic        exception_in,
   input  logic [3:0]  exception_code_in,
   input  logic [63:0] tval_in,
   input  logic        mret_in,
   input  logic        mstatus_mie_in,
   input  logic        mstatus_mpie_in,
   input  logic [2:0]  mie_in,
   input  logic [2:0]  mip_in,
   input  logic [63:0] mtvec_in,
   input  logic [63:0] mepc_in,
   output logic        trap_write_out,
   output logic [63:0] mepc_out,
   output logic [63:0] mcause_out,
   output logic [63:0] mtval_out,
   output logic        mstatus_write_out,
   output logic        mstatus_mie_out,
   output logic        mstatus_mpie_out,
   output logic        redirect_valid_out,
   output logic [63:0] redirect_pc_out,
   output logic        flush_out,
   output logic        busy_out
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] SAVE     = 2'd1;
   localparam logic [1:0] RESTORE  = 2'd2;
   localparam logic [1:0] REDIRECT = 2'd3;

   localparam logic [3:0] CODE_MEI = 4'd11;
   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;

   logic [1:0]  state_q,  state_d;
   logic [63:0] mepc_q,   mepc_d;
   logic [63:0] mcause_q, mcause_d;
   logic [63:0] mtval_q,  mtval_d;
   logic [63:0] target_q, target_d;

   // Event decode: exception > MRET > interrupt, sampled only in IDLE.
   logic [2:0]  irq_en;
   logic        irq_pending;
   logic [3:0]  irq_code;
   logic        can_sample;
   logic        take_exc;
   logic        take_mret;
   logic        take_irq;
   logic        accept;
   logic [63:0] tvec_base;

   assign irq_en      = mie_in & mip_in;
   assign irq_pending = mstatus_mie_in & (|irq_en);
   assign irq_code    = irq_en[2] ? CODE_MEI : (irq_en[0] ? CODE_MSI : CODE_MTI);
   assign can_sample  = (state_q == IDLE) && !stall_in && instr_valid_in;
   assign take_exc    = can_sample && exception_in;
   assign take_mret   = can_sample && !exception_in && mret_in;
   assign take_irq    = can_sample && !exception_in && !mret_in && irq_pending;
   assign accept      = take_exc || take_mret || take_irq;
   assign tvec_base   = {mtvec_in[63:2], 2'b00};

   // State and latched-value registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         mepc_q   <= 64'd0;
         mcause_q <= 64'd0;
         mtval_q  <= 64'd0;
         target_q <= 64'd0;
      end else begin
         state_q  <= state_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
         mtval_q  <= mtval_d;
         target_q <= target_d;
      end
   end

   // Next-state and capture logic
   always_comb begin
      state_d  = state_q;
      mepc_d   = mepc_q;
      mcause_d = mcause_q;
      mtval_d  = mtval_q;
      target_d = target_q;
      if (!stall_in) begin
         case (state_q)
            IDLE: begin
               if (take_exc) begin
                  state_d  = SAVE;
                  mepc_d   = pc_in;
                  mcause_d = {60'd0, exception_code_in};
                  mtval_d  = tval_in;
                  target_d = tvec_base;
               end else if (take_mret) begin
                  state_d  = RESTORE;
                  target_d = {mepc_in[63:2], 2'b00};
               end else if (take_irq) begin
                  state_d  = SAVE;
                  mepc_d   = pc_in;
                  mcause_d = {1'b1, 59'd0, irq_code};
                  mtval_d  = 64'd0;
                  // Vectored mode wraps naturally in 64 bits.
                  target_d = mtvec_in[0] ? (tvec_base + {58'd0, irq_code, 2'b00})
                                         : tvec_base;
               end
            end
            SAVE:     state_d = REDIRECT;
            RESTORE:  state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
         endcase
      end
   end

   // Output decode
   always_comb begin
      trap_write_out     = 1'b0;
      mepc_out           = 64'd0;
      mcause_out         = 64'd0;
      mtval_out          = 64'd0;
      mstatus_write_out  = 1'b0;
      mstatus_mie_out    = 1'b0;
      mstatus_mpie_out   = 1'b0;
      redirect_valid_out = 1'b0;
      redirect_pc_out    = 64'd0;
      flush_out          = 1'b0;
      busy_out           = 1'b0;
      case (state_q)
         IDLE: begin
            flush_out = accept;
         end
         SAVE: begin
            trap_write_out    = 1'b1;
            mepc_out          = mepc_q;
            mcause_out        = mcause_q;
            mtval_out         = mtval_q;
            mstatus_write_out = 1'b1;
            mstatus_mpie_out  = mstatus_mie_in;
            flush_out         = 1'b1;
            busy_out          = 1'b1;
         end
         RESTORE: begin
            mstatus_write_out = 1'b1;
            mstatus_mie_out   = mstatus_mpie_in;
            mstatus_mpie_out  = 1'b1;
            flush_out         = 1'b1;
            busy_out          = 1'b1;
         end
         REDIRECT: begin
            redirect_valid_out = 1'b1;
            redirect_pc_out    = target_q;
            flush_out          = 1'b1;
            busy_out           = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Directed self-checking bench for trap_ctrl
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_in;
   logic        instr_valid_in;
   logic [63:0] pc_in;
   logic        exception_in;
   logic [3:0]  exception_code_in;
   logic [63:0] tval_in;
   logic        mret_in;
   logic        mstatus_mie_in;
   logic        mstatus_mpie_in;
   logic [2:0]  mie_in;
   logic [2:0]  mip_in;
   logic [63:0] mtvec_in;
   logic [63:0] mepc_in;
   logic        trap_write_out;
   logic [63:0] mepc_out;
   logic [63:0] mcause_out;
   logic [63:0] mtval_out;
   logic        mstatus_write_out;
   logic        mstatus_mie_out;
   logic        mstatus_mpie_out;
   logic        redirect_valid_out;
   logic [63:0] redirect_pc_out;
   logic        flush_out;
   logic        busy_out;

   int n_checks = 0;
   int n_errors = 0;

   trap_ctrl dut (
      .clk                (clk),
      .reset              (reset),
      .stall_in           (stall_in),
      .instr_valid_in     (instr_valid_in),
      .pc_in              (pc_in),
      .exception_in       (exception_in),
      .exception_code_in  (exception_code_in),
      .tval_in            (tval_in),
      .mret_in            (mret_in),
      .mstatus_mie_in     (mstatus_mie_in),
      .mstatus_mpie_in    (mstatus_mpie_in),
      .mie_in             (mie_in),
      .mip_in             (mip_in),
      .mtvec_in           (mtvec_in),
      .mepc_in            (mepc_in),
      .trap_write_out     (trap_write_out),
      .mepc_out           (mepc_out),
      .mcause_out         (mcause_out),
      .mtval_out          (mtval_out),
      .mstatus_write_out  (mstatus_write_out),
      .mstatus_mie_out    (mstatus_mie_out),
      .mstatus_mpie_out   (mstatus_mpie_out),
      .redirect_valid_out (redirect_valid_out),
      .redirect_pc_out    (redirect_pc_out),
      .flush_out          (flush_out),
      .busy_out           (busy_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall_in          = 1'b0;
      instr_valid_in    = 1'b0;
      pc_in             = 64'd0;
      exception_in      = 1'b0;
      exception_code_in = 4'd0;
      tval_in           = 64'd0;
      mret_in           = 1'b0;
      mstatus_mie_in    = 1'b0;
      mstatus_mpie_in   = 1'b0;
      mie_in            = 3'b000;
      mip_in            = 3'b000;
      mtvec_in          = 64'd0;
      mepc_in           = 64'd0;
   endtask

   task automatic drop_event();
      instr_valid_in = 1'b0;
      exception_in   = 1'b0;
      mret_in        = 1'b0;
      mip_in         = 3'b000;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("rst_busy",     {63'd0, busy_out}, 64'd0);
      check("rst_flush",    {63'd0, flush_out}, 64'd0);
      check("rst_trapwr",   {63'd0, trap_write_out}, 64'd0);
      check("rst_redir",    {63'd0, redirect_valid_out}, 64'd0);
      check("rst_mstwr",    {63'd0, mstatus_write_out}, 64'd0);
      check("rst_mepc",     mepc_out, 64'd0);
      check("rst_redir_pc", redirect_pc_out, 64'd0);

      // Exception, direct target despite vectored mode
      mstatus_mie_in    = 1'b1;
      mtvec_in          = 64'h8001;
      pc_in             = 64'h1000;
      exception_in      = 1'b1;
      exception_code_in = 4'd2;
      tval_in           = 64'hDEAD;
      instr_valid_in    = 1'b1;
      #1;
      check("exc_flush_n",  {63'd0, flush_out}, 64'd1);
      check("exc_busy_n",   {63'd0, busy_out}, 64'd0);
      tick();
      drop_event();
      #1;
      check("exc_trapwr",   {63'd0, trap_write_out}, 64'd1);
      check("exc_mepc",     mepc_out, 64'h1000);
      check("exc_mcause",   mcause_out, 64'd2);
      check("exc_mtval",    mtval_out, 64'hDEAD);
      check("exc_mstwr",    {63'd0, mstatus_write_out}, 64'd1);
      check("exc_mie_o",    {63'd0, mstatus_mie_out}, 64'd0);
      check("exc_mpie_o",   {63'd0, mstatus_mpie_out}, 64'd1);
      check("exc_noredir",  {63'd0, redirect_valid_out}, 64'd0);
      tick();
      check("exc_redir",    {63'd0, redirect_valid_out}, 64'd1);
      check("exc_redir_pc", redirect_pc_out, 64'h8000);
      check("exc_trapwr0",  {63'd0, trap_write_out}, 64'd0);
      tick();
      check("exc_idle",     {63'd0, busy_out}, 64'd0);
      check("exc_pc0",      redirect_pc_out, 64'd0);

      // Vectored timer interrupt
      clear_inputs();
      mstatus_mie_in = 1'b1;
      mie_in         = 3'b010;
      mip_in         = 3'b010;
      mtvec_in       = 64'h8001;
      pc_in          = 64'h2000;
      tval_in        = 64'h1234;
      instr_valid_in = 1'b1;
      tick();
      drop_event();
      #1;
      check("tmr_mcause",   mcause_out, 64'h8000_0000_0000_0007);
      check("tmr_mtval",    mtval_out, 64'd0);
      check("tmr_mepc",     mepc_out, 64'h2000);
      check("tmr_mie_o",    {63'd0, mstatus_mie_out}, 64'd0);
      check("tmr_mpie_o",   {63'd0, mstatus_mpie_out}, 64'd1);
      tick();
      check("tmr_redir_pc", redirect_pc_out, 64'h801C);
      tick();

      // All interrupts pending: MEI wins; vectored target wraps, mtvec[1] ignored
      clear_inputs();
      mstatus_mie_in = 1'b1;
      mie_in         = 3'b111;
      mip_in         = 3'b111;
      mtvec_in       = 64'hFFFF_FFFF_FFFF_FFFF;
      pc_in          = 64'h2100;
      instr_valid_in = 1'b1;
      tick();
      drop_event();
      #1;
      check("mei_mcause",   mcause_out, 64'h8000_0000_0000_000B);
      tick();
      check("mei_wrap_pc",  redirect_pc_out, 64'h28);
      tick();

      // Masked by mstatus.MIE
      clear_inputs();
      mie_in         = 3'b111;
      mip_in         = 3'b111;
      instr_valid_in = 1'b1;
      #1;
      check("mask_flush",   {63'd0, flush_out}, 64'd0);
      tick();
      check("mask_busy",    {63'd0, busy_out}, 64'd0);
      check("mask_trapwr",  {63'd0, trap_write_out}, 64'd0);

      // MRET
      clear_inputs();
      mepc_in         = 64'h3006;
      mstatus_mpie_in = 1'b1;
      mret_in         = 1'b1;
      instr_valid_in  = 1'b1;
      tick();
      drop_event();
      #1;
      check("mret_mstwr",   {63'd0, mstatus_write_out}, 64'd1);
      check("mret_mie_o",   {63'd0, mstatus_mie_out}, 64'd1);
      check("mret_mpie_o",  {63'd0, mstatus_mpie_out}, 64'd1);
      check("mret_trapwr",  {63'd0, trap_write_out}, 64'd0);
      tick();
      check("mret_redir",   redirect_pc_out, 64'h3004);
      tick();

      // Exception, MRET and interrupt together: exception path
      clear_inputs();
      mstatus_mie_in    = 1'b1;
      mie_in            = 3'b111;
      mip_in            = 3'b111;
      mtvec_in          = 64'h8001;
      mepc_in           = 64'h3006;
      pc_in             = 64'h4000;
      exception_in      = 1'b1;
      exception_code_in = 4'd5;
      tval_in           = 64'h77;
      mret_in           = 1'b1;
      instr_valid_in    = 1'b1;
      tick();
      drop_event();
      #1;
      check("pri_trapwr",   {63'd0, trap_write_out}, 64'd1);
      check("pri_mcause",   mcause_out, 64'd5);
      check("pri_mtval",    mtval_out, 64'h77);
      tick();
      check("pri_redir_pc", redirect_pc_out, 64'h8000);
      tick();

      // Stall held 3 cycles in SAVE
      clear_inputs();
      mtvec_in          = 64'h8001;
      pc_in             = 64'h5000;
      exception_in      = 1'b1;
      exception_code_in = 4'd3;
      instr_valid_in    = 1'b1;
      tick();
      drop_event();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stl_trapwr", {63'd0, trap_write_out}, 64'd1);
         check("stl_noredir", {63'd0, redirect_valid_out}, 64'd0);
      end
      stall_in = 1'b0;
      #1;
      check("stl_trapwr_r", {63'd0, trap_write_out}, 64'd1);
      tick();
      check("stl_redir",    {63'd0, redirect_valid_out}, 64'd1);
      check("stl_redir_pc", redirect_pc_out, 64'h8000);
      tick();

      // Reset in SAVE abandons the trap
      clear_inputs();
      mtvec_in          = 64'h8001;
      pc_in             = 64'h6000;
      exception_in      = 1'b1;
      exception_code_in = 4'd1;
      instr_valid_in    = 1'b1;
      tick();
      drop_event();
      #1;
      check("rs_save",      {63'd0, trap_write_out}, 64'd1);
      reset    = 1'b1;
      stall_in = 1'b1;
      tick();
      reset    = 1'b0;
      stall_in = 1'b0;
      #1;
      check("rs_busy",      {63'd0, busy_out}, 64'd0);
      check("rs_trapwr",    {63'd0, trap_write_out}, 64'd0);
      check("rs_mepc",      mepc_out, 64'd0);
      check("rs_flush",     {63'd0, flush_out}, 64'd0);
      tick();
      check("rs_noredir",   {63'd0, redirect_valid_out}, 64'd0);
      check("rs_pc0",       redirect_pc_out, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
